// File: rtl/dmem_responder_pkg.sv
// Shared encodings for the M-stage data-memory responder: load types, store lane
// enables and the responder FSM state.
package dmem_responder_pkg;

  // Load-type codes, identical to the M-stage DEOp encoding
  localparam logic [1:0] LD_NONE = 2'b00;
  localparam logic [1:0] LD_W    = 2'b01;
  localparam logic [1:0] LD_H    = 2'b10;
  localparam logic [1:0] LD_B    = 2'b11;

  localparam logic [3:0] BE_NONE = 4'b0000;
  localparam logic [3:0] BE_W    = 4'b1111;
  localparam logic [3:0] BE_H0   = 4'b0011;
  localparam logic [3:0] BE_H1   = 4'b1100;
  localparam logic [3:0] BE_B0   = 4'b0001;
  localparam logic [3:0] BE_B1   = 4'b0010;
  localparam logic [3:0] BE_B2   = 4'b0100;
  localparam logic [3:0] BE_B3   = 4'b1000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_t;

endpackage

// File: rtl/dmem_responder_load_extender.sv
// Selects the addressed half/byte of a 32-bit word and sign-extends it; shared by
// the pipeline loaders.
module load_extender
  import dmem_responder_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  byte_off,
  input  logic [1:0]  load_type,
  output logic [31:0] data
);

  logic [15:0] half;
  logic [7:0]  lane;

  always_comb begin
    half = byte_off[1] ? word[31:16] : word[15:0];
    lane = word[8*byte_off +: 8];
    case (load_type)
      LD_W:    data = word;
      LD_H:    data = {{16{half[15]}}, half};
      LD_B:    data = {{24{lane[7]}}, lane};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory responder: latches a request, waits WAIT_CYCLES,
// then performs the byte-masked store or extended load and pulses a response.
//
// state   | meaning
// IDLE    | no request in flight, ready to accept
// WAIT    | request latched, counting down wait states
// RESP    | response valid this cycle, may accept the next request
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [3:0]  req_be,
  input  logic [31:0] req_wdata,
  input  logic [1:0]  req_load,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy
);

  localparam int WORDS = 2 ** ADDR_WIDTH;

  state_t                state;
  logic [3:0]            counter;
  logic [31:0]           lat_addr;
  logic [31:0]           lat_wdata;
  logic [3:0]            lat_be;
  logic [1:0]            lat_load;
  logic [31:0]           mem [WORDS];
  logic [ADDR_WIDTH-1:0] word_idx;
  logic [31:0]           ext_data;
  logic                  accept;
  logic                  access;
  logic                  access_err;

  assign req_ready = (state == ST_IDLE) || (state == ST_RESP);
  assign accept    = req_valid && req_ready;
  assign busy      = (state == ST_WAIT);
  assign rsp_valid = (state == ST_RESP);
  assign access    = (state == ST_WAIT) && (counter == 4'd0);
  assign word_idx  = lat_addr[ADDR_WIDTH+1:2];

  always_comb begin
    access_err = 1'b0;
    if ((lat_addr >> (ADDR_WIDTH + 2)) != 32'd0)       access_err = 1'b1;
    if (lat_load == LD_W && lat_addr[1:0] != 2'b00)    access_err = 1'b1;
    if (lat_load == LD_H && lat_addr[0])               access_err = 1'b1;
    if (lat_be != BE_NONE && lat_load != LD_NONE)      access_err = 1'b1;
  end

  load_extender u_load_extender (
    .word      (mem[word_idx]),
    .byte_off  (lat_addr[1:0]),
    .load_type (lat_load),
    .data      (ext_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= ST_IDLE;
      counter   <= '0;
      lat_addr  <= '0;
      lat_wdata <= '0;
      lat_be    <= '0;
      lat_load  <= '0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
    end else begin
      if (accept) begin
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_be    <= req_be;
        lat_load  <= req_load;
        counter   <= 4'(WAIT_CYCLES);
      end
      case (state)
        ST_IDLE: if (accept) state <= ST_WAIT;
        ST_WAIT: begin
          if (counter != 4'd0) begin
            counter <= counter - 4'd1;
          end else begin
            rsp_rdata <= access_err ? 32'd0 : ext_data;
            rsp_err   <= access_err;
            state     <= ST_RESP;
          end
        end
        ST_RESP: begin
          rsp_rdata <= '0;
          rsp_err   <= 1'b0;
          state     <= accept ? ST_WAIT : ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  // The array is deliberately outside the reset domain; an aborted store never reaches here
  always_ff @(posedge clk) begin
    if (access && !access_err) begin
      for (int i = 0; i < 4; i++) begin
        if (lat_be[i]) mem[word_idx][8*i +: 8] <= lat_wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: directed vector table, reset-abort and
// back-to-back sequences, then random traffic against a byte-level memory model.
module tb_dmem_responder;
  import dmem_responder_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [3:0]  req_be = '0;
  logic [31:0] req_wdata = '0;
  logic [1:0]  req_load = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        busy;

  int checks = 0;
  int failures = 0;
  logic [31:0] model_mem [4096];

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_WIDTH(12), .WAIT_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_be(req_be), .req_wdata(req_wdata), .req_load(req_load),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  typedef struct {
    string       name;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [1:0]  ld;
    logic [31:0] rd;
    logic        err;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Reference: byte array semantics with integer sign extension
  task automatic model_access(input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [1:0] ld,
                              output logic [31:0] rd, output logic err);
    logic [31:0] w;
    int off;
    int v;
    err = (addr >= 32'h4000) || (ld == LD_W && addr % 4 != 0) ||
          (ld == LD_H && addr % 2 != 0) || (be != 4'd0 && ld != LD_NONE);
    rd = 32'd0;
    if (err) return;
    w = model_mem[addr[13:2]];
    for (int i = 0; i < 4; i++) if (be[i]) w[8*i +: 8] = wdata[8*i +: 8];
    model_mem[addr[13:2]] = w;
    off = int'(addr % 4);
    case (ld)
      LD_W: rd = w;
      LD_H: begin
        v = int'((w >> (8 * (off & 2))) & 32'hFFFF);
        if (v >= 32768) v = v - 65536;
        rd = 32'(v);
      end
      LD_B: begin
        v = int'((w >> (8 * off)) & 32'hFF);
        if (v >= 128) v = v - 256;
        rd = 32'(v);
      end
      default: rd = 32'd0;
    endcase
  endtask

  // lat = cycles from accept edge to response; 99 if the pulse is too long or data lingers
  task automatic issue(input logic [31:0] addr, input logic [3:0] be, input logic [31:0] wdata,
                       input logic [1:0] ld, output logic [31:0] rd, output logic err,
                       output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_addr = addr; req_be = be; req_wdata = wdata; req_load = ld;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_be = '0; req_load = '0;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    rd = rsp_rdata;
    err = rsp_err;
    @(negedge clk);
    if (rsp_valid || rsp_rdata != 32'd0 || rsp_err) lat = 99;
  endtask

  function automatic vec_t mk(input string name, input logic [31:0] addr, input logic [3:0] be,
                              input logic [31:0] wdata, input logic [1:0] ld,
                              input logic [31:0] rd, input logic err);
    vec_t v;
    v.name = name; v.addr = addr; v.be = be; v.wdata = wdata; v.ld = ld; v.rd = rd; v.err = err;
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd, mrd;
    logic        err, merr;
    int          lat, cnt;
    logic [31:0] b_addr [3];
    logic [1:0]  b_ld [3];
    logic [31:0] b_exp [3];
    int          acc [3];
    int          rsp [3];
    logic [31:0] rdv [3];
    int          n_acc, n_rsp, cyc, busy_bad;
    logic        rdy, pending;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [1:0]  ld;

    vecs.push_back(mk("st_word",      32'h10,   BE_W,  32'hDEADBEEF, LD_NONE, 32'h0,        1'b0));
    vecs.push_back(mk("lw_10",        32'h10,   BE_NONE, 32'h0,      LD_W,    32'hDEADBEEF, 1'b0));
    vecs.push_back(mk("st_byte1",     32'h11,   BE_B1, 32'h00005500, LD_NONE, 32'h0,        1'b0));
    vecs.push_back(mk("lw_10_merged", 32'h10,   BE_NONE, 32'h0,      LD_W,    32'hDEAD55EF, 1'b0));
    vecs.push_back(mk("lb_11",        32'h11,   BE_NONE, 32'h0,      LD_B,    32'h00000055, 1'b0));
    vecs.push_back(mk("lb_13",        32'h13,   BE_NONE, 32'h0,      LD_B,    32'hFFFFFFDE, 1'b0));
    vecs.push_back(mk("lb_10",        32'h10,   BE_NONE, 32'h0,      LD_B,    32'hFFFFFFEF, 1'b0));
    vecs.push_back(mk("lh_12",        32'h12,   BE_NONE, 32'h0,      LD_H,    32'hFFFFDEAD, 1'b0));
    vecs.push_back(mk("lh_10",        32'h10,   BE_NONE, 32'h0,      LD_H,    32'h000055EF, 1'b0));
    vecs.push_back(mk("lh_11_misal",  32'h11,   BE_NONE, 32'h0,      LD_H,    32'h0,        1'b1));
    vecs.push_back(mk("lw_12_misal",  32'h12,   BE_NONE, 32'h0,      LD_W,    32'h0,        1'b1));
    vecs.push_back(mk("st_word0",     32'h0,    BE_W,  32'h11223344, LD_NONE, 32'h0,        1'b0));
    vecs.push_back(mk("st_range",     32'h4000, BE_W,  32'h99999999, LD_NONE, 32'h0,        1'b1));
    vecs.push_back(mk("lw_0_after_rng", 32'h0,  BE_NONE, 32'h0,      LD_W,    32'h11223344, 1'b0));
    vecs.push_back(mk("conflict",     32'h0,    BE_B0, 32'h000000AA, LD_W,    32'h0,        1'b1));
    vecs.push_back(mk("lw_0_after_cf", 32'h0,   BE_NONE, 32'h0,      LD_W,    32'h11223344, 1'b0));
    vecs.push_back(mk("lw_range",     32'h4000, BE_NONE, 32'h0,      LD_W,    32'h0,        1'b1));
    vecs.push_back(mk("noop",         32'h8,    BE_NONE, 32'h0,      LD_NONE, 32'h0,        1'b0));
    vecs.push_back(mk("st_top",       32'h3FFC, BE_W,  32'h80000001, LD_NONE, 32'h0,        1'b0));
    vecs.push_back(mk("lb_top",       32'h3FFF, BE_NONE, 32'h0,      LD_B,    32'hFFFFFF80, 1'b0));
    vecs.push_back(mk("lw_top",       32'h3FFC, BE_NONE, 32'h0,      LD_W,    32'h80000001, 1'b0));
    vecs.push_back(mk("st_20",        32'h20,   BE_W,  32'hCAFEF00D, LD_NONE, 32'h0,        1'b0));

    // Reset state
    #2 reset = 1'b1;
    #1;
    check("rst_ready", 32'(req_ready), 32'd1);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_rdata", rsp_rdata, 32'd0);
    check("rst_err",   32'(rsp_err), 32'd0);
    check("rst_busy",  32'(busy), 32'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;

    foreach (vecs[i]) begin
      issue(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].ld, rd, err, lat);
      model_access(vecs[i].addr, vecs[i].be, vecs[i].wdata, vecs[i].ld, mrd, merr);
      check({vecs[i].name, "_rdata"}, rd, vecs[i].rd);
      check({vecs[i].name, "_err"}, 32'(err), 32'(vecs[i].err));
      check({vecs[i].name, "_latency"}, 32'(lat), 32'd3);
    end

    // Reset during the wait phase of a store aborts it
    @(negedge clk);
    req_valid = 1'b1; req_addr = 32'h20; req_be = BE_W; req_wdata = 32'h12345678; req_load = LD_NONE;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_be = '0;
    check("abort_busy_before", 32'(busy), 32'd1);
    reset = 1'b1;
    #1;
    check("abort_ready", 32'(req_ready), 32'd1);
    check("abort_valid", 32'(rsp_valid), 32'd0);
    check("abort_rdata", rsp_rdata, 32'd0);
    check("abort_err",   32'(rsp_err), 32'd0);
    check("abort_busy",  32'(busy), 32'd0);
    cnt = 0;
    repeat (2) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    reset = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("abort_no_response", 32'(cnt), 32'd0);
    issue(32'h20, BE_NONE, 32'h0, LD_W, rd, err, lat);
    check("abort_mem_kept", rd, 32'hCAFEF00D);

    // Back-to-back with req_valid held
    b_addr[0] = 32'h10; b_ld[0] = LD_W; b_exp[0] = 32'hDEAD55EF;
    b_addr[1] = 32'h11; b_ld[1] = LD_B; b_exp[1] = 32'h00000055;
    b_addr[2] = 32'h20; b_ld[2] = LD_W; b_exp[2] = 32'hCAFEF00D;
    n_acc = 0; n_rsp = 0; cyc = 0; busy_bad = 0; pending = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_addr = b_addr[0]; req_load = b_ld[0]; req_be = BE_NONE;
    while (n_rsp < 3 && cyc < 60) begin
      rdy = req_ready;
      @(posedge clk);
      cyc++;
      if (rdy && req_valid && n_acc < 3) begin
        acc[n_acc] = cyc;
        n_acc++;
        pending = 1'b1;
      end
      @(negedge clk);
      if (n_acc < 3) begin
        req_addr = b_addr[n_acc]; req_load = b_ld[n_acc];
      end else begin
        req_valid = 1'b0; req_load = LD_NONE;
      end
      if (busy != (pending && !rsp_valid)) busy_bad++;
      if (rsp_valid) begin
        rsp[n_rsp] = cyc;
        rdv[n_rsp] = rsp_rdata;
        n_rsp++;
        pending = 1'b0;
      end
    end
    check("b2b_responses", 32'(n_rsp), 32'd3);
    check("b2b_busy_only_in_wait", 32'(busy_bad), 32'd0);
    if (n_rsp == 3) begin
      for (int i = 0; i < 3; i++) begin
        check($sformatf("b2b_rdata%0d", i), rdv[i], b_exp[i]);
        check($sformatf("b2b_latency%0d", i), 32'(rsp[i] - acc[i]), 32'd3);
      end
      for (int i = 0; i < 2; i++) begin
        check($sformatf("b2b_accept_on_resp%0d", i), 32'(acc[i+1] - rsp[i]), 32'd1);
        check($sformatf("b2b_spacing%0d", i), 32'(rsp[i+1] - rsp[i]), 32'd4);
      end
    end
    @(negedge clk);
    check("b2b_idle_after", 32'({rsp_valid, busy, req_ready}), 32'b001);

    // Random traffic over a region that is fully initialised first
    for (int i = 0; i < 16; i++) begin
      addr = 32'h100 + 32'(4 * i);
      wdata = $urandom;
      issue(addr, BE_W, wdata, LD_NONE, rd, err, lat);
      model_access(addr, BE_W, wdata, LD_NONE, mrd, merr);
      check("rnd_init_err", 32'(err), 32'(merr));
    end
    for (int i = 0; i < 200; i++) begin
      addr = 32'h100 + 32'($urandom_range(0, 63));
      if ($urandom_range(0, 9) == 0) addr = addr | (32'h1 << $urandom_range(14, 31));
      wdata = $urandom;
      be = BE_NONE;
      ld = LD_NONE;
      case ($urandom_range(0, 3))
        0: case ($urandom_range(0, 6))
             0: be = BE_W;  1: be = BE_H0; 2: be = BE_H1; 3: be = BE_B0;
             4: be = BE_B1; 5: be = BE_B2; default: be = BE_B3;
           endcase
        1, 2: ld = 2'($urandom_range(1, 3));
        default: if ($urandom_range(0, 1) == 1) begin
                   be = 4'($urandom_range(1, 15));
                   ld = 2'($urandom_range(1, 3));
                 end
      endcase
      issue(addr, be, wdata, ld, rd, err, lat);
      model_access(addr, be, wdata, ld, mrd, merr);
      check($sformatf("rnd%0d_rdata a=%h be=%b ld=%0d", i, addr, be, ld), rd, mrd);
      check($sformatf("rnd%0d_err", i), 32'(err), 32'(merr));
      check($sformatf("rnd%0d_latency", i), 32'(lat), 32'd3);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
- Memory-side responder for the M-stage data-memory interface.
- Accepts one load or store request at a time: byte-lane write enables, lane-aligned write data, and a load-type code.
- Waits a programmable number of cycles, then performs the byte-masked write or the read.
- Returns the read data sign-extended, or flags an error. Sits between the M-stage controller/bridge and the data RAM array.

Parameters:
- ADDR_WIDTH, 12: word-address bits; the array holds 2^ADDR_WIDTH 32-bit words.
- WAIT_CYCLES, 2: extra wait states before the access; legal range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted at this edge if req_valid.
- req_addr  in  32  byte address.
- req_be  in  4  store byte-lane enables; 0000 means no store.
- req_wdata  in  32  store data, already placed in the enabled lanes.
- req_load  in  2  load type: 00 none, 01 word, 10 half signed, 11 byte signed.
- rsp_valid  out  1  one-cycle response pulse.
- rsp_rdata  out  32  extended load data; 0 for stores, no-ops and errors.
- rsp_err  out  1  qualified by rsp_valid.
- busy  out  1  high when the state is WAIT.

Behaviour:
- Reset state: IDLE. Outputs at reset: req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0, counter=0.
- Reset does not touch the memory array.
- Reset asserted mid-transaction aborts it: no write occurs and no response is issued.
- States are IDLE, WAIT and RESP.
- req_ready = (state==IDLE) || (state==RESP).
- Accept condition: req_valid && req_ready at a rising edge. On accept:
  - latch addr, be, wdata and load;
  - load counter = WAIT_CYCLES;
  - go to WAIT.
- WAIT, counter != 0: decrement the counter each edge.
- WAIT, counter == 0: at that edge perform the access, register rsp_rdata and rsp_err, go to RESP.
- RESP: rsp_valid=1 for exactly one cycle.
  - Next edge goes to WAIT if a new request is accepted, else to IDLE.
  - rsp_rdata and rsp_err return to 0 when leaving RESP without a new response.
- Timing: request accepted at edge 0 gives rsp_valid during the cycle after edge WAIT_CYCLES+1.
- Back-to-back requests (held valid through RESP) give a response spacing of WAIT_CYCLES+2 cycles.
- Word index = addr[ADDR_WIDTH+1:2].
- Store: for each i with be[i]=1, mem byte lane i <= wdata[8i+7:8i]. Other lanes are unchanged.
- Load word: returns the whole word.
- Load half: addr[1] selects half (0 selects [15:0], 1 selects [31:16]); result sign-extended to 32 bits.
- Load byte: addr[1:0] selects lane; result sign-extended to 32 bits.
- Error conditions (rsp_err=1, rsp_rdata=0, no write):
  - addr[31:ADDR_WIDTH+2] != 0 (out of range);
  - word load with addr[1:0]!=0;
  - half load with addr[0]!=0;
  - be!=0000 and load!=00 together.
- No-op: be=0000 and load=00 still completes with rsp_valid=1, rsp_err=0, rdata=0.
- Store enable patterns other than 1111, 0011, 1100 or a single byte are not checked; they are written as given.
- WAIT_CYCLES=0: response is in the cycle after edge 1.

Decomposition:
- Shared package holds:
  - load-type constants LD_NONE=00, LD_W=01, LD_H=10, LD_B=11, matching the M-stage DEOp encoding;
  - store enable constants BE_W=1111, BE_H0=0011, BE_H1=1100, BE_B0..BE_B3;
  - FSM state encoding.
- One combinational sub-module, load_extender (inputs: word, addr[1:0], load type; output: 32-bit extended data), reused by the other loaders in the pipeline.

Test Plan (WAIT_CYCLES=2, ADDR_WIDTH=12):
1. Store and word load: after reset, store be=1111, addr 0x10, wdata 0xDEADBEEF, then load word addr 0x10 -> rsp_rdata=0xDEADBEEF, rsp_err=0. Each rsp_valid is exactly one cycle, in the cycle after edge 3 following its accept.
2. Byte store and byte loads: store be=0010, addr 0x11, wdata 0x00005500.
   - load word 0x10 -> 0xDEAD55EF;
   - load byte 0x11 -> 0x00000055;
   - load byte 0x13 -> 0xFFFFFFDE.
3. Half loads: load half 0x12 -> 0xFFFFDEAD. Load half 0x11 -> rsp_err=1, rsp_rdata=0. Load word 0x12 -> rsp_err=1.
4. Range and conflict errors: store be=1111 addr 0x4000 -> rsp_err=1, memory unchanged. Request with be=0001 and load=01 -> rsp_err=1, no write.
5. Reset mid-store: assert reset during WAIT of a store of 0x12345678 to 0x20 (0x20 previously 0xCAFEF00D).
   - All outputs 0 immediately, except req_ready=1.
   - No response is issued.
   - A subsequent load word 0x20 -> 0xCAFEF00D.
6. Back-to-back: req_valid held across 3 requests -> each accepted on its predecessor's RESP cycle, rsp_valid pulses spaced 4 cycles apart, busy high only in WAIT.
